// File: rtl/ks0108_panel_rx.sv
// rtl/ks0108_panel_rx.sv - dual-chip KS0108-style LCD bus responder with shadow frame RAM
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   db_i, dori_i, rw_i       LCD data bus, data/instruction select, read/write
//   en_i                     enable strobe; a transaction commits on its falling edge
//   cs_i[1:0]                active-high chip selects (0 = left, 1 = right)
//   lcd_rst_i                panel reset from the driver
//   rd_addr_i, rd_data_o     read-back port {chip, page, col}, 1-cycle latency
//   disp_on_o                per-chip display-on flag
//   start_line_o             {chip1 start, chip0 start}
//   wr_count_o               saturating count of committed data transactions
//   err_o                    sticky protocol-error flag
module ks0108_panel_rx #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       db_i,
    input  logic             dori_i,
    input  logic             en_i,
    input  logic             rw_i,
    input  logic [1:0]       cs_i,
    input  logic             lcd_rst_i,
    input  logic [9:0]       rd_addr_i,
    output logic [7:0]       rd_data_o,
    output logic [1:0]       disp_on_o,
    output logic [11:0]      start_line_o,
    output logic [CNT_W-1:0] wr_count_o,
    output logic             err_o
);

    logic [7:0] db_q;
    logic       dori_q;
    logic       rw_q;
    logic [1:0] cs_q;
    logic       en_q;

    logic [5:0] y     [2];
    logic [2:0] page  [2];
    logic [5:0] start [2];
    logic [1:0] on;

    logic [7:0] bank0 [512];
    logic [7:0] bank1 [512];

    logic       commit;
    logic       cmd_legal;
    logic       bus_err;
    logic       data_wr;
    logic [1:0] wr_en;

    // The transaction uses the bus as sampled in the last en-high cycle.
    // A panel reset in the same cycle swallows the commit.
    assign commit = en_q && !en_i && !lcd_rst_i && (cs_q != 2'b00);

    always_comb begin
        cmd_legal = 1'b0;
        if (db_q == 8'h3E || db_q == 8'h3F)  cmd_legal = 1'b1;
        else if (db_q[7:6] == 2'b01)         cmd_legal = 1'b1;
        else if (db_q[7:3] == 5'b10111)      cmd_legal = 1'b1;
        else if (db_q[7:6] == 2'b11)         cmd_legal = 1'b1;
    end

    assign bus_err = commit && (rw_q || (!dori_q && !cmd_legal));
    assign data_wr = commit && !rw_q && dori_q;
    assign wr_en   = data_wr ? cs_q : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            db_q   <= '0;
            dori_q <= 1'b0;
            rw_q   <= 1'b0;
            cs_q   <= '0;
            en_q   <= 1'b0;
        end else begin
            db_q   <= db_i;
            dori_q <= dori_i;
            rw_q   <= rw_i;
            cs_q   <= cs_i;
            en_q   <= en_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || lcd_rst_i) begin
            for (int c = 0; c < 2; c++) begin
                y[c]     <= '0;
                page[c]  <= '0;
                start[c] <= '0;
            end
            on <= '0;
        end else if (commit && !rw_q) begin
            for (int c = 0; c < 2; c++) begin
                if (cs_q[c]) begin
                    if (dori_q)                      y[c]     <= y[c] + 6'd1;
                    else if (db_q == 8'h3E)          on[c]    <= 1'b0;
                    else if (db_q == 8'h3F)          on[c]    <= 1'b1;
                    else if (db_q[7:6] == 2'b01)     y[c]     <= db_q[5:0];
                    else if (db_q[7:3] == 5'b10111)  page[c]  <= db_q[2:0];
                    else if (db_q[7:6] == 2'b11)     start[c] <= db_q[5:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count_o <= '0;
            err_o      <= 1'b0;
        end else begin
            if (data_wr && wr_count_o != {CNT_W{1'b1}})
                wr_count_o <= wr_count_o + 1'b1;
            if (bus_err)
                err_o <= 1'b1;
        end
    end

    // One bank per chip so a dual-select write lands in both at once.
    always_ff @(posedge clk) begin
        if (wr_en[0]) bank0[{page[0], y[0]}] <= db_q;
        if (wr_en[1]) bank1[{page[1], y[1]}] <= db_q;
    end

    // Read-first: a same-cycle write is seen on the following read.
    always_ff @(posedge clk) begin
        if (rst)               rd_data_o <= '0;
        else if (rd_addr_i[9]) rd_data_o <= bank1[rd_addr_i[8:0]];
        else                   rd_data_o <= bank0[rd_addr_i[8:0]];
    end

    assign disp_on_o    = on;
    assign start_line_o = {start[1], start[0]};

endmodule

// File: tb/tb_ks0108_panel_rx.sv
// tb/tb_ks0108_panel_rx.sv - self-checking bench for ks0108_panel_rx
module tb_ks0108_panel_rx;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  db_i;
    logic        dori_i;
    logic        en_i;
    logic        rw_i;
    logic [1:0]  cs_i;
    logic        lcd_rst_i;
    logic [9:0]  rd_addr_i;
    logic [7:0]  rd_data_o;
    logic [1:0]  disp_on_o;
    logic [11:0] start_line_o;
    logic [15:0] wr_count_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    ks0108_panel_rx #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .db_i(db_i), .dori_i(dori_i), .en_i(en_i),
        .rw_i(rw_i), .cs_i(cs_i), .lcd_rst_i(lcd_rst_i), .rd_addr_i(rd_addr_i),
        .rd_data_o(rd_data_o), .disp_on_o(disp_on_o), .start_line_o(start_line_o),
        .wr_count_o(wr_count_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  db;
        logic        dori;
        logic        rw;
        logic [1:0]  cs;
        logic [1:0]  exp_on;
        logic [11:0] exp_start;
        logic [15:0] exp_cnt;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } rd_t;

    vec_t vecs[23];
    rd_t  rds[8];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus(input logic [7:0] db, input logic dori, input logic rw, input logic [1:0] cs);
        @(negedge clk);
        db_i = db; dori_i = dori; rw_i = rw; cs_i = cs; en_i = 1'b1;
        @(negedge clk);
        en_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic rd(input string name, input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        rd_addr_i = a;
        @(negedge clk);
        chk(name, rd_data_o, d);
    endtask

    task automatic chk_state(input string tag, input logic [1:0] on, input logic [11:0] st,
                             input logic [15:0] cnt, input logic err);
        chk({tag, " disp_on"}, disp_on_o, on);
        chk({tag, " start_line"}, start_line_o, st);
        chk({tag, " wr_count"}, wr_count_o, cnt);
        chk({tag, " err"}, err_o, err);
    endtask

    initial begin
        vecs[0]  = '{8'h3F, 1'b0, 1'b0, 2'b01, 2'b01, 12'h000, 16'd0, 1'b0};
        vecs[1]  = '{8'hBA, 1'b0, 1'b0, 2'b01, 2'b01, 12'h000, 16'd0, 1'b0};
        vecs[2]  = '{8'h45, 1'b0, 1'b0, 2'b01, 2'b01, 12'h000, 16'd0, 1'b0};
        vecs[3]  = '{8'hA5, 1'b1, 1'b0, 2'b01, 2'b01, 12'h000, 16'd1, 1'b0};
        vecs[4]  = '{8'h5A, 1'b1, 1'b0, 2'b01, 2'b01, 12'h000, 16'd2, 1'b0};
        vecs[5]  = '{8'hC7, 1'b0, 1'b0, 2'b10, 2'b01, 12'h1C0, 16'd2, 1'b0};
        vecs[6]  = '{8'h3F, 1'b0, 1'b0, 2'b10, 2'b11, 12'h1C0, 16'd2, 1'b0};
        vecs[7]  = '{8'hB8, 1'b0, 1'b0, 2'b10, 2'b11, 12'h1C0, 16'd2, 1'b0};
        vecs[8]  = '{8'h7F, 1'b0, 1'b0, 2'b10, 2'b11, 12'h1C0, 16'd2, 1'b0};
        vecs[9]  = '{8'h11, 1'b1, 1'b0, 2'b10, 2'b11, 12'h1C0, 16'd3, 1'b0};
        vecs[10] = '{8'h22, 1'b1, 1'b0, 2'b10, 2'b11, 12'h1C0, 16'd4, 1'b0};
        vecs[11] = '{8'h33, 1'b1, 1'b0, 2'b10, 2'b11, 12'h1C0, 16'd5, 1'b0};
        vecs[12] = '{8'hB8, 1'b0, 1'b0, 2'b11, 2'b11, 12'h1C0, 16'd5, 1'b0};
        vecs[13] = '{8'h43, 1'b0, 1'b0, 2'b01, 2'b11, 12'h1C0, 16'd5, 1'b0};
        vecs[14] = '{8'h47, 1'b0, 1'b0, 2'b10, 2'b11, 12'h1C0, 16'd5, 1'b0};
        vecs[15] = '{8'h3C, 1'b1, 1'b0, 2'b11, 2'b11, 12'h1C0, 16'd6, 1'b0};
        vecs[16] = '{8'h3E, 1'b0, 1'b0, 2'b01, 2'b10, 12'h1C0, 16'd6, 1'b0};
        vecs[17] = '{8'hC5, 1'b0, 1'b0, 2'b01, 2'b10, 12'h1C5, 16'd6, 1'b0};
        vecs[18] = '{8'h99, 1'b1, 1'b0, 2'b00, 2'b10, 12'h1C5, 16'd6, 1'b0};
        vecs[19] = '{8'h90, 1'b0, 1'b0, 2'b01, 2'b10, 12'h1C5, 16'd6, 1'b1};
        vecs[20] = '{8'hEE, 1'b1, 1'b1, 2'b01, 2'b10, 12'h1C5, 16'd6, 1'b1};
        vecs[21] = '{8'h44, 1'b1, 1'b0, 2'b01, 2'b10, 12'h1C5, 16'd7, 1'b1};
        vecs[22] = '{8'h3F, 1'b0, 1'b0, 2'b01, 2'b11, 12'h1C5, 16'd7, 1'b1};

        rds[0] = '{10'h085, 8'hA5};
        rds[1] = '{10'h086, 8'h5A};
        rds[2] = '{10'h23F, 8'h11};
        rds[3] = '{10'h200, 8'h22};
        rds[4] = '{10'h201, 8'h33};
        rds[5] = '{10'h003, 8'h3C};
        rds[6] = '{10'h207, 8'h3C};
        rds[7] = '{10'h004, 8'h44};

        rst = 1'b1; db_i = 8'h00; dori_i = 1'b0; rw_i = 1'b0; cs_i = 2'b00;
        en_i = 1'b0; lcd_rst_i = 1'b0; rd_addr_i = '0;

        // Reset with en toggling and no chip selected.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            en_i = ~en_i;
        end
        @(negedge clk);
        rst = 1'b0; en_i = 1'b0;
        @(negedge clk);
        chk_state("reset", 2'b00, 12'h000, 16'd0, 1'b0);
        chk("reset rd_data", rd_data_o, 8'h00);

        for (int i = 0; i < 23; i++) begin
            bus(vecs[i].db, vecs[i].dori, vecs[i].rw, vecs[i].cs);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_on, vecs[i].exp_start,
                      vecs[i].exp_cnt, vecs[i].exp_err);
        end

        for (int i = 0; i < 8; i++)
            rd($sformatf("read 0x%03h", rds[i].addr), rds[i].addr, rds[i].data);

        // Panel reset after page=5, Y=20 on chip 0.
        bus(8'hBD, 1'b0, 1'b0, 2'b01);
        bus(8'h54, 1'b0, 1'b0, 2'b01);
        @(negedge clk); lcd_rst_i = 1'b1;
        @(negedge clk); lcd_rst_i = 1'b0;
        chk_state("lcd_rst", 2'b00, 12'h000, 16'd7, 1'b1);
        bus(8'h77, 1'b1, 1'b0, 2'b01);
        chk("post lcd_rst count", wr_count_o, 16'd8);
        rd("lcd_rst write 0x000", 10'h000, 8'h77);
        rd("retained 0x085", 10'h085, 8'hA5);
        rd("retained 0x23F", 10'h23F, 8'h11);

        // Commit coinciding with panel reset is discarded.
        @(negedge clk);
        db_i = 8'h66; dori_i = 1'b1; rw_i = 1'b0; cs_i = 2'b01; en_i = 1'b1;
        @(negedge clk);
        en_i = 1'b0; lcd_rst_i = 1'b1;
        @(negedge clk);
        lcd_rst_i = 1'b0;
        chk("discarded commit count", wr_count_o, 16'd8);
        bus(8'h88, 1'b1, 1'b0, 2'b01);
        chk("after discard count", wr_count_o, 16'd9);
        rd("after discard 0x000", 10'h000, 8'h88);

        // Back-to-back one-high one-low strobes.
        @(negedge clk); db_i = 8'hD1; dori_i = 1'b1; cs_i = 2'b01; en_i = 1'b1;
        @(negedge clk); en_i = 1'b0;
        @(negedge clk); db_i = 8'hD2; en_i = 1'b1;
        @(negedge clk); en_i = 1'b0;
        @(negedge clk);
        chk("fast strobe count", wr_count_o, 16'd11);
        rd("fast 0x001", 10'h001, 8'hD1);
        rd("fast 0x002", 10'h002, 8'hD2);

        // Read-first on a same-cycle write to the watched address.
        @(negedge clk); rd_addr_i = 10'h003;
        bus(8'hE4, 1'b1, 1'b0, 2'b01);
        chk("read-first old", rd_data_o, 8'h3C);
        @(negedge clk);
        chk("read-first new", rd_data_o, 8'hE4);
        chk("read-first count", wr_count_o, 16'd12);

        // Only rst clears the sticky error.
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        chk_state("final rst", 2'b00, 12'h000, 16'd0, 1'b0);
        chk("final rst rd_data", rd_data_o, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
